fixed_activation_rr_scheduler: RTL and testbench

FIXED_ACTIVATION_RR_SCHEDULER -- requirements
Module: fixed_activation_rr_scheduler

---
 rtl/fixed_activation_rr_scheduler_pkg.sv | 26 ++
 rtl/fixed_activation_rr_scheduler_rr_arbiter.sv | 38 +++
 rtl/fixed_activation_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_fixed_activation_rr_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_activation_rr_scheduler_pkg.sv
// Shared types and parameter helpers for the round-robin activation scheduler.
package fixed_activation_rr_scheduler_pkg;

    // Scheduler FSM: IDLE arbitrates, STREAM moves one whole tensor.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sched_state_t;

    // Index width for a set of n items, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a requester index.
    function automatic int calc_idw(input int num_req);
        return idx_width(num_req);
    endfunction

    // Number of beats that make up one tensor.
    function automatic int calc_beats(input int size_0, input int size_1,
                                      input int par_0, input int par_1);
        return (size_0 * size_1) / (par_0 * par_1);
    endfunction

endpackage

// File: rtl/fixed_activation_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter
    import fixed_activation_rr_scheduler_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = calc_idw(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_valid
);

    logic [IDW:0]   sum_s;
    logic [IDW-1:0] cand_s;
    logic           hit_s;

    // Walk the requesters starting at ptr; the first one found wins.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        sum_s        = '0;
        cand_s       = '0;
        hit_s        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s       = {1'b0, ptr} + (IDW+1)'(i);
            cand_s      = (sum_s >= (IDW+1)'(NUM_REQ)) ? IDW'(sum_s - (IDW+1)'(NUM_REQ))
                                                      : sum_s[IDW-1:0];
            hit_s       = !grant_valid && req[cand_s];
            grant_idx   = hit_s ? cand_s : grant_idx;
            grant_valid = grant_valid | hit_s;
        end
        grant_onehot = NUM_REQ'(grant_valid) << grant_idx;
    end

endmodule

// File: rtl/fixed_activation_rr_scheduler.sv
// Shares one combinational activation core between NUM_REQ tensor streams,
// granting whole tensors round-robin and registering the core result.
module fixed_activation_rr_scheduler
    import fixed_activation_rr_scheduler_pkg::*;
#(
    parameter  int NUM_REQ                     = 4,
    parameter  int DATA_IN_0_PRECISION_0       = 8,
    parameter  int DATA_IN_0_PRECISION_1       = 4,
    parameter  int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter  int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter  int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter  int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    localparam int P   = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1,
    localparam int W   = DATA_IN_0_PRECISION_0,
    localparam int IDW = calc_idw(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       data_in_0 [NUM_REQ*P],
    input  logic [NUM_REQ-1:0] data_in_0_valid,
    output logic [NUM_REQ-1:0] data_in_0_ready,
    output logic [W-1:0]       act_data_in [P],
    input  logic [W-1:0]       act_data_out [P],
    output logic [W-1:0]       data_out_0 [P],
    output logic               data_out_0_valid,
    input  logic               data_out_0_ready,
    output logic [IDW-1:0]     data_out_0_id,
    output logic               data_out_0_last
);

    localparam int BEATS = calc_beats(DATA_IN_0_TENSOR_SIZE_DIM_0, DATA_IN_0_TENSOR_SIZE_DIM_1,
                                      DATA_IN_0_PARALLELISM_DIM_0, DATA_IN_0_PARALLELISM_DIM_1);
    localparam int CW    = idx_width(BEATS);

    // Reject parameter sets the datapath is not built for.
    if ((NUM_REQ < 2) || (NUM_REQ > 16) || (BEATS < 1) ||
        (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0)) begin : g_cfg_check
        $error("fixed_activation_rr_scheduler: unsupported parameter set");
    end

    sched_state_t       state_r;
    sched_state_t       state_s;
    logic [IDW-1:0]     grant_r;
    logic [NUM_REQ-1:0] grant_oh_r;
    logic [IDW-1:0]     rr_ptr_r;
    logic [CW-1:0]      beat_cnt_r;

    logic [NUM_REQ-1:0] arb_oh_s;
    logic [IDW-1:0]     arb_idx_s;
    logic               arb_valid_s;
    logic [IDW-1:0]     next_ptr_s;
    logic               out_slot_free_s;
    logic               accept_s;
    logic               last_s;

    rr_arbiter #(
        .NUM_REQ      (NUM_REQ)
    ) u_rr_arbiter (
        .req          (data_in_0_valid),
        .ptr          (rr_ptr_r),
        .grant_onehot (arb_oh_s),
        .grant_idx    (arb_idx_s),
        .grant_valid  (arb_valid_s)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign out_slot_free_s = !data_out_0_valid || data_out_0_ready;
    assign last_s          = (beat_cnt_r == CW'(BEATS - 1));
    assign next_ptr_s      = (grant_r == IDW'(NUM_REQ - 1)) ? '0 : grant_r + IDW'(1);

    // Next state, per-requester ready, core input mux and beat acceptance.
    always_comb begin
        state_s         = state_r;
        data_in_0_ready = '0;
        accept_s        = 1'b0;
        for (int e = 0; e < P; e++) begin
            act_data_in[e] = '0;
        end
        case (state_r)
            IDLE: begin
                state_s = arb_valid_s ? STREAM : IDLE;
            end
            STREAM: begin
                data_in_0_ready = grant_oh_r & {NUM_REQ{out_slot_free_s}};
                accept_s        = (|(data_in_0_valid & grant_oh_r)) && out_slot_free_s;
                for (int r = 0; r < NUM_REQ; r++) begin
                    for (int e = 0; e < P; e++) begin
                        act_data_in[e] = act_data_in[e] | (data_in_0[r*P + e] & {W{grant_oh_r[r]}});
                    end
                end
                state_s = (accept_s && last_s) ? IDLE : STREAM;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, grant latch, beat counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            grant_oh_r <= '0;
            rr_ptr_r   <= '0;
            beat_cnt_r <= '0;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && arb_valid_s) begin
                grant_r    <= arb_idx_s;
                grant_oh_r <= arb_oh_s;
            end
            if (accept_s) begin
                if (last_s) begin
                    beat_cnt_r <= '0;
                    rr_ptr_r   <= next_ptr_s;
                end else begin
                    beat_cnt_r <= beat_cnt_r + CW'(1);
                end
            end
        end
    end

    // Output register: loads the core result on accept, holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < P; e++) begin
                data_out_0[e] <= '0;
            end
            data_out_0_id    <= '0;
            data_out_0_last  <= 1'b0;
            data_out_0_valid <= 1'b0;
        end else if (accept_s) begin
            for (int e = 0; e < P; e++) begin
                data_out_0[e] <= act_data_out[e];
            end
            data_out_0_id    <= grant_r;
            data_out_0_last  <= last_s;
            data_out_0_valid <= 1'b1;
        end else if (data_out_0_ready) begin
            data_out_0_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fixed_activation_rr_scheduler.sv
// Scoreboard bench for fixed_activation_rr_scheduler: a tensor-level reference
// model predicts grants and output beats, a monitor compares the DUT each cycle.
module tb_fixed_activation_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int W       = 8;
    localparam int P       = 1;
    localparam int BEATS   = 8;
    localparam int IDW     = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [W-1:0]       data_in_0 [NUM_REQ*P];
    logic [NUM_REQ-1:0] data_in_0_valid;
    logic [NUM_REQ-1:0] data_in_0_ready;
    logic [W-1:0]       act_data_in [P];
    logic [W-1:0]       act_data_out [P];
    logic [W-1:0]       data_out_0 [P];
    logic               data_out_0_valid;
    logic               data_out_0_ready;
    logic [IDW-1:0]     data_out_0_id;
    logic               data_out_0_last;

    fixed_activation_rr_scheduler #(
        .NUM_REQ                     (NUM_REQ),
        .DATA_IN_0_PRECISION_0       (W),
        .DATA_IN_0_PRECISION_1       (4),
        .DATA_IN_0_TENSOR_SIZE_DIM_0 (BEATS),
        .DATA_IN_0_TENSOR_SIZE_DIM_1 (1),
        .DATA_IN_0_PARALLELISM_DIM_0 (1),
        .DATA_IN_0_PARALLELISM_DIM_1 (1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (data_in_0),
        .data_in_0_valid  (data_in_0_valid),
        .data_in_0_ready  (data_in_0_ready),
        .act_data_in      (act_data_in),
        .act_data_out     (act_data_out),
        .data_out_0       (data_out_0),
        .data_out_0_valid (data_out_0_valid),
        .data_out_0_ready (data_out_0_ready),
        .data_out_0_id    (data_out_0_id),
        .data_out_0_last  (data_out_0_last)
    );

    always #5 clk = ~clk;

    // Stand-in activation core: a fixed XOR so wrong slices are visible.
    always_comb act_data_out[0] = act_data_in[0] ^ 8'hA5;

    typedef struct {
        logic [W-1:0]   data;
        logic [IDW-1:0] id;
        logic           last;
    } beat_t;

    beat_t sb_q[$];
    int    m_grants[$];
    int    exp_g[$];

    bit m_stream;
    bit m_out_valid;
    bit m_after_rst;
    int m_g;
    int m_ptr;
    int m_cnt;
    int m_tensors;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tensor-granular round robin, evaluated at each rising edge.
    initial begin
        bit    free;
        bit    acc;
        int    r;
        beat_t nb;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_stream    = 1'b0;
                m_out_valid = 1'b0;
                m_after_rst = 1'b1;
                m_g         = 0;
                m_ptr       = 0;
                m_cnt       = 0;
                sb_q.delete();
            end else begin
                free = !m_out_valid || data_out_0_ready;
                acc  = 1'b0;
                if (!m_stream) begin
                    if (data_in_0_valid != '0) begin
                        for (int k = 0; k < NUM_REQ; k++) begin
                            r = (m_ptr + k) % NUM_REQ;
                            if (data_in_0_valid[r]) begin
                                m_g = r;
                                break;
                            end
                        end
                        m_stream = 1'b1;
                        m_grants.push_back(m_g);
                    end
                end else if (data_in_0_valid[m_g] && free) begin
                    acc     = 1'b1;
                    nb.data = data_in_0[m_g] ^ 8'hA5;
                    nb.id   = IDW'(m_g);
                    nb.last = (m_cnt == BEATS - 1);
                    sb_q.push_back(nb);
                    if (m_cnt == BEATS - 1) begin
                        m_cnt    = 0;
                        m_ptr    = (m_g + 1) % NUM_REQ;
                        m_stream = 1'b0;
                        m_tensors++;
                    end else begin
                        m_cnt++;
                    end
                end
                if (acc) begin
                    m_out_valid = 1'b1;
                    m_after_rst = 1'b0;
                end else if (data_out_0_ready) begin
                    m_out_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: compares handshakes and pops the scoreboard on each completed beat.
    initial begin
        logic [NUM_REQ-1:0] exp_ready;
        beat_t              front;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_ready = (m_stream && (!m_out_valid || data_out_0_ready)) ? (4'b0001 << m_g) : 4'b0000;
            check("in_ready", data_in_0_ready, exp_ready);
            check("act_in", act_data_in[0], m_stream ? data_in_0[m_g] : 8'h00);
            check("out_valid", data_out_0_valid, m_out_valid);
            if (m_after_rst) begin
                check("rst_data", data_out_0[0], 8'h00);
                check("rst_id", data_out_0_id, 2'd0);
                check("rst_last", data_out_0_last, 1'b0);
            end
            if (data_out_0_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    front = sb_q[0];
                    check("out_data", data_out_0[0], front.data);
                    check("out_id", data_out_0_id, front.id);
                    check("out_last", data_out_0_last, front.last);
                    if (data_out_0_ready) begin
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ*P; i++) begin
            data_in_0[i] = W'($urandom);
        end
        case (rdy_mode)
            1:       data_out_0_ready = ($urandom_range(0, 3) != 0);
            2:       data_out_0_ready = 1'b0;
            default: data_out_0_ready = 1'b1;
        endcase
    endtask

    task automatic wait_tensors(input int target, input int budget, input string name);
        int n = 0;
        while ((m_tensors < target) && (n < budget)) begin
            cycle();
            n++;
        end
        check(name, m_tensors, target);
    endtask

    task automatic wait_cnt(input int c, input int budget, input string name);
        int n = 0;
        while (!(m_stream && (m_cnt == c)) && (n < budget)) begin
            cycle();
            n++;
        end
        check(name, m_cnt, c);
    endtask

    task automatic check_grants(input string name);
        check({name, "_count"}, m_grants.size(), exp_g.size());
        for (int i = 0; (i < exp_g.size()) && (i < m_grants.size()); i++) begin
            check(name, m_grants[i], exp_g[i]);
        end
    endtask

    // Stimulus: directed phases followed by a randomized soak.
    initial begin
        rst              = 1'b1;
        data_in_0_valid  = '0;
        data_out_0_ready = 1'b1;
        for (int i = 0; i < NUM_REQ*P; i++) begin
            data_in_0[i] = '0;
        end
        repeat (3) cycle();
        rst = 1'b0;

        // Single requester 1: eight beats, id 1, last on the eighth.
        m_grants.delete();
        data_in_0_valid = 4'b0010;
        wait_tensors(m_tensors + 1, 40, "p1_tensor");
        data_in_0_valid = '0;
        exp_g = '{1};
        check_grants("p1_grant");
        repeat (3) cycle();

        // Requesters 0 and 2 from reset: 0 first, one idle cycle, then 2.
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        m_grants.delete();
        data_in_0_valid = 4'b0101;
        wait_tensors(m_tensors + 2, 60, "p2_tensor");
        data_in_0_valid = '0;
        exp_g = '{0, 2};
        check_grants("p2_grant");
        repeat (3) cycle();

        // All four valid with pointer at 3, random output backpressure.
        m_grants.delete();
        rdy_mode        = 1;
        data_in_0_valid = 4'b1111;
        wait_tensors(m_tensors + 5, 400, "p3_tensor");
        data_in_0_valid = '0;
        rdy_mode        = 0;
        exp_g = '{3, 0, 1, 2, 3};
        check_grants("p3_grant");
        repeat (3) cycle();

        // Output stalled five cycles mid-tensor.
        m_grants.delete();
        data_in_0_valid = 4'b1111;
        wait_cnt(3, 40, "p4_cnt");
        rdy_mode = 2;
        repeat (5) cycle();
        rdy_mode = 0;
        wait_tensors(m_tensors + 1, 40, "p4_tensor");
        data_in_0_valid = '0;
        exp_g = '{0};
        check_grants("p4_grant");
        repeat (3) cycle();

        // Granted requester drops valid for four cycles after beat 2.
        m_grants.delete();
        data_in_0_valid = 4'b0100;
        wait_cnt(2, 40, "p5_cnt");
        data_in_0_valid = '0;
        repeat (4) cycle();
        data_in_0_valid = 4'b0100;
        wait_tensors(m_tensors + 1, 40, "p5_tensor");
        data_in_0_valid = '0;
        exp_g = '{2};
        check_grants("p5_grant");
        repeat (3) cycle();

        // Reset after beat 3 of requester 0; pointer must restart at 0.
        m_grants.delete();
        data_in_0_valid = 4'b0001;
        wait_cnt(3, 40, "p6_cnt");
        data_in_0_valid = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        data_in_0_valid = 4'b1010;
        wait_tensors(m_tensors + 1, 40, "p6_tensor");
        data_in_0_valid = '0;
        exp_g = '{0, 1};
        check_grants("p6_grant");
        repeat (3) cycle();

        // Random valids and backpressure against the model.
        rdy_mode = 1;
        for (int n = 0; n < 600; n++) begin
            cycle();
            data_in_0_valid = NUM_REQ'($urandom);
        end
        data_in_0_valid = '0;
        rdy_mode        = 0;
        repeat (20) cycle();
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
